// File: rtl/bus_fifo_slave.sv
// bus_fifo_slave: memory-mapped 64-bit FIFO on a single-cycle bus slave port.
// DATA pushes/pops, STATUS reports flags and fill level, CTRL flushes and
// clears the sticky flags, THRESH sets the interrupt level. Read data is
// registered; irq is decoded from registered state.
module bus_fifo_slave #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        irq
);

    localparam int             CW         = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
    localparam logic [7:0]     THRESH_RST = 8'(DEPTH);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_THRESH = 3'd3;

    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r, unf_r;
    logic [7:0]    thresh_r;
    logic [63:0]   dout_r;

    logic [AW-1:0] wr_ptr_s, rd_ptr_s;
    logic [CW-1:0] count_s;
    logic          ovf_s, unf_s;
    logic [7:0]    thresh_s;
    logic [63:0]   dout_s;
    logic          mem_we_s;

    logic          empty_s, full_s;
    logic [7:0]    count8_s;
    logic [8:0]    count_ext_s;
    logic [8:0]    thresh_ext_s;
    logic [63:0]   status_s;

    assign empty_s      = (count_r == '0);
    assign full_s       = (count_r == DEPTH_C);
    assign count8_s     = 8'(count_r);
    assign count_ext_s  = 9'(count_r);
    assign thresh_ext_s = {1'b0, thresh_r};
    assign status_s     = {48'd0, count8_s, 4'd0, ovf_r, unf_r, full_s, empty_s};

    assign s_dout = dout_r;
    assign irq    = (thresh_r != 8'd0) && (count_ext_s >= thresh_ext_s);

    // Decode the current access and compute the next register state.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        ovf_s    = ovf_r;
        unf_s    = unf_r;
        thresh_s = thresh_r;
        dout_s   = dout_r;
        mem_we_s = 1'b0;
        if (s_sel) begin
            if (s_wr) begin
                case (s_addr[2:0])
                    ADDR_DATA: begin
                        if (!full_s) begin
                            mem_we_s = 1'b1;
                            wr_ptr_s = wr_ptr_r + PTR_ONE;
                            count_s  = count_r + CNT_ONE;
                        end else begin
                            ovf_s = 1'b1;
                        end
                    end
                    ADDR_CTRL: begin
                        // Flush and flag-clear are independent and may combine.
                        wr_ptr_s = s_din[0] ? '0 : wr_ptr_r;
                        rd_ptr_s = s_din[0] ? '0 : rd_ptr_r;
                        count_s  = s_din[0] ? '0 : count_r;
                        ovf_s    = s_din[1] ? 1'b0 : ovf_r;
                        unf_s    = s_din[1] ? 1'b0 : unf_r;
                    end
                    ADDR_THRESH: begin
                        thresh_s = s_din[7:0];
                    end
                    default: begin
                        mem_we_s = 1'b0;
                    end
                endcase
            end else begin
                case (s_addr[2:0])
                    ADDR_DATA: begin
                        if (!empty_s) begin
                            dout_s   = mem_r[rd_ptr_r];
                            rd_ptr_s = rd_ptr_r + PTR_ONE;
                            count_s  = count_r - CNT_ONE;
                        end else begin
                            dout_s = 64'd0;
                            unf_s  = 1'b1;
                        end
                    end
                    ADDR_STATUS: dout_s = status_s;
                    ADDR_THRESH: dout_s = {56'd0, thresh_r};
                    default:     dout_s = 64'd0;
                endcase
            end
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Control/status registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            thresh_r <= THRESH_RST;
            dout_r   <= 64'd0;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            count_r  <= count_s;
            ovf_r    <= ovf_s;
            unf_r    <= unf_s;
            thresh_r <= thresh_s;
            dout_r   <= dout_s;
        end
    end

    // FIFO storage; contents are meaningless after reset or flush.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r] <= s_din;
        end
    end

endmodule
